// File: rtl/instr_decode.sv
// instr_decode: instruction register, one-hot opcode decoder and condition-flag
// stage feeding the CPU controller FSM.
//   clock, reset        : system clock, async active-high reset
//   ir_load, bus_in     : capture instruction word into IR (ignored while halted)
//   flag_load, acc      : capture zero/negative flags from the accumulator
//   LDA..HLT            : one-hot decoded opcode lines (gated by ir_valid)
//   addr_out            : IR address field
//   zero_flag, neg_flag : registered condition flags
//   take_jump           : resolved jump decision for JMP/JPZ/JPN
//   halted              : sticky halt, cleared only by reset
//   illegal             : IR holds an undefined opcode
//   instr_count         : modulo-256 count of accepted instruction loads
module instr_decode #(
  parameter int DATA_W = 8,
  parameter int OPC_W  = 4,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ir_load,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              flag_load,
  input  logic [DATA_W-1:0] acc,
  output logic              LDA,
  output logic              STA,
  output logic              ADD,
  output logic              SUB,
  output logic              XOR,
  output logic              INC,
  output logic              CLR,
  output logic              JMP,
  output logic              JPZ,
  output logic              JPN,
  output logic              HLT,
  output logic [ADDR_W-1:0] addr_out,
  output logic              zero_flag,
  output logic              neg_flag,
  output logic              take_jump,
  output logic              halted,
  output logic              illegal,
  output logic [7:0]        instr_count
);

  typedef enum logic [OPC_W-1:0] {
    OP_LDA = 'd0,
    OP_STA = 'd1,
    OP_ADD = 'd2,
    OP_SUB = 'd3,
    OP_XOR = 'd4,
    OP_INC = 'd5,
    OP_CLR = 'd6,
    OP_JMP = 'd7,
    OP_JPZ = 'd8,
    OP_JPN = 'd9,
    OP_HLT = 'd15
  } opcode_e;

  logic [DATA_W-1:0] ir_q;
  logic              ir_valid_q;
  logic              zero_q;
  logic              neg_q;
  logic              halted_q;
  logic              halted_d;
  logic [7:0]        count_q;
  logic              accept;
  opcode_e           opcode;

  // Raw (ungated) decode of the IR opcode field
  logic lda_r, sta_r, add_r, sub_r, xor_r, inc_r, clr_r, jmp_r, jpz_r, jpn_r, hlt_r, ill_r;

  assign accept = ir_load & ~halted_q;
  assign opcode = opcode_e'(ir_q[DATA_W-1 -: OPC_W]);

  always_comb begin
    lda_r = 1'b0; sta_r = 1'b0; add_r = 1'b0; sub_r = 1'b0;
    xor_r = 1'b0; inc_r = 1'b0; clr_r = 1'b0; jmp_r = 1'b0;
    jpz_r = 1'b0; jpn_r = 1'b0; hlt_r = 1'b0; ill_r = 1'b0;
    case (opcode)
      OP_LDA:  lda_r = 1'b1;
      OP_STA:  sta_r = 1'b1;
      OP_ADD:  add_r = 1'b1;
      OP_SUB:  sub_r = 1'b1;
      OP_XOR:  xor_r = 1'b1;
      OP_INC:  inc_r = 1'b1;
      OP_CLR:  clr_r = 1'b1;
      OP_JMP:  jmp_r = 1'b1;
      OP_JPZ:  jpz_r = 1'b1;
      OP_JPN:  jpn_r = 1'b1;
      OP_HLT:  hlt_r = 1'b1;
      default: ill_r = 1'b1;
    endcase
  end

  assign LDA     = ir_valid_q & lda_r;
  assign STA     = ir_valid_q & sta_r;
  assign ADD     = ir_valid_q & add_r;
  assign SUB     = ir_valid_q & sub_r;
  assign XOR     = ir_valid_q & xor_r;
  assign INC     = ir_valid_q & inc_r;
  assign CLR     = ir_valid_q & clr_r;
  assign JMP     = ir_valid_q & jmp_r;
  assign JPZ     = ir_valid_q & jpz_r;
  assign JPN     = ir_valid_q & jpn_r;
  assign HLT     = ir_valid_q & hlt_r;
  assign illegal = ir_valid_q & ill_r;

  assign take_jump = JMP | (JPZ & zero_q) | (JPN & neg_q);

  // A load accepted on the edge right after HLT was captured replaces HLT,
  // so the halt must not be latched on that same edge.
  assign halted_d = halted_q | (HLT & ~accept);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      zero_q     <= 1'b0;
      neg_q      <= 1'b0;
      halted_q   <= 1'b0;
      count_q    <= '0;
    end else begin
      if (accept) begin
        ir_q       <= bus_in;
        ir_valid_q <= 1'b1;
        count_q    <= count_q + 8'd1;
      end
      if (flag_load) begin
        zero_q <= (acc == '0);
        neg_q  <= acc[DATA_W-1];
      end
      halted_q <= halted_d;
    end
  end

  assign addr_out    = ir_q[ADDR_W-1:0];
  assign zero_flag   = zero_q;
  assign neg_flag    = neg_q;
  assign halted      = halted_q;
  assign instr_count = count_q;

endmodule
